// File: rtl/ahbl_bus_gen_pkg.sv
// Shared AHB-lite encodings, default-slave state type and bus data width
// for the ahbl_bus_gen address decoder / response mux.
package ahbl_bus_gen_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response FSM
// plus capture of the first unmapped access.
module ahbl_default_slave
  import ahbl_bus_gen_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              unmapped_i,
  input  logic [1:0]        htrans_i,
  input  logic              hready_i,
  input  logic [DATA_W-1:0] haddr_i,
  input  logic              hwrite_i,
  input  logic              err_clr_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic              err_valid_o,
  output logic [DATA_W-1:0] err_addr_o,
  output logic              err_write_o
);

  ds_state_e         state_q, state_d;
  logic              err_valid_q, err_valid_d;
  logic              err_write_q, err_write_d;
  logic [DATA_W-1:0] err_addr_q, err_addr_d;
  logic              err_acc;

  assign err_acc = unmapped_i & hready_i & is_active(htrans_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DS_OK;
      err_valid_q <= 1'b0;
      err_write_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_valid_q <= err_valid_d;
      err_write_q <= err_write_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      DS_OK: begin
        if (err_acc) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        state_d = err_acc ? DS_ERR1 : DS_OK;
      end
      default: state_d = DS_OK;
    endcase
  end

  // A new error arriving together with err_clr is captured, not dropped.
  always_comb begin
    err_valid_d = err_valid_q;
    err_write_d = err_write_q;
    err_addr_d  = err_addr_q;
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_write_d = 1'b0;
    end
    if (err_acc && (!err_valid_q || err_clr_i)) begin
      err_valid_d = 1'b1;
      err_write_d = hwrite_i;
      err_addr_d  = haddr_i;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_write_o = err_write_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: rtl/ahbl_bus_gen.sv
// AHB-lite bus generator: address decode, data-phase select register,
// AND-OR response mux, slave stall watchdog and default slave.
module ahbl_bus_gen
  import ahbl_bus_gen_pkg::*;
#(
  parameter int                            NUM_SLAVES  = 6,
  parameter int                            DEC_BITS    = 8,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLV_BASE   = 48'h504C_4840_2000,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLV_MASK   = {(NUM_SLAVES*DEC_BITS){1'b1}},
  parameter int                            TIMEOUT_CYC = 1024
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [31:0]                  HRDATA,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  output logic                         err_valid,
  output logic [31:0]                  err_addr,
  output logic                         err_write,
  output logic                         timeout,
  input  logic                         err_clr
);

  localparam int                CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [DEC_BITS-1:0]   dec_field;
  logic [NUM_SLAVES-1:0] sel_a;
  logic                  sel_hit;
  logic [NUM_SLAVES:0]   dsel_q, dsel_d;
  logic                  hready_m, hresp_m;
  logic [DATA_W-1:0]     hrdata_m;
  logic                  ds_ready, ds_resp;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  timeout_q, timeout_d;

  assign dec_field = HADDR[31 -: DEC_BITS];

  // Lowest-index match wins, so overlapping windows still give one-hot.
  always_comb begin
    sel_a   = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!sel_hit &&
          ((dec_field & SLV_MASK[i*DEC_BITS +: DEC_BITS]) ==
           (SLV_BASE[i*DEC_BITS +: DEC_BITS] & SLV_MASK[i*DEC_BITS +: DEC_BITS]))) begin
        sel_a[i] = 1'b1;
        sel_hit  = 1'b1;
      end
    end
  end

  assign HSEL_S = sel_a;
  assign dsel_d = HREADY ? {~sel_hit, sel_a} : dsel_q;

  // Empty select (after reset) reads as a zero-wait OKAY with zero data.
  always_comb begin
    hready_m = ~|dsel_q;
    hresp_m  = 1'b0;
    hrdata_m = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hready_m = hready_m | (dsel_q[i] & HREADYOUT_S[i]);
      hresp_m  = hresp_m | (dsel_q[i] & HRESP_S[i]);
      hrdata_m = hrdata_m | (HRDATA_S[i*DATA_W +: DATA_W] & {DATA_W{dsel_q[i]}});
    end
    hready_m = hready_m | (dsel_q[NUM_SLAVES] & ds_ready);
    hresp_m  = hresp_m | (dsel_q[NUM_SLAVES] & ds_resp);
  end

  assign HREADY = hready_m;
  assign HRESP  = hresp_m;
  assign HRDATA = hrdata_m;

  // With TIMEOUT_CYC=0 the count already sits at CNT_MAX and never moves.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q & ~err_clr;
    if (HREADY) begin
      stall_cnt_d = '0;
    end else if ((|dsel_q[NUM_SLAVES-1:0]) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (stall_cnt_d == CNT_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      dsel_q      <= dsel_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout = timeout_q;

  ahbl_default_slave u_default_slave (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .unmapped_i  (~sel_hit),
    .htrans_i    (HTRANS),
    .hready_i    (HREADY),
    .haddr_i     (HADDR),
    .hwrite_i    (HWRITE),
    .err_clr_i   (err_clr),
    .hreadyout_o (ds_ready),
    .hresp_o     (ds_resp),
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_write_o (err_write)
  );

endmodule

// File: tb/tb_ahbl_bus_gen.sv
// Bench for ahbl_bus_gen: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_ahbl_bus_gen;
  import ahbl_bus_gen_pkg::*;

  localparam int NS = 6;
  localparam int TO = 4;
  localparam int M_BASE [NS] = '{8'h48, 8'h20, 8'h40, 8'h48, 8'h4C, 8'h50};
  localparam int M_MASK [NS] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0};

  logic             clk = 1'b0;
  logic             HRESET;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic             HREADY, HRESP;
  logic [31:0]      HRDATA;
  logic [NS-1:0]    HSEL_S;
  logic [NS-1:0]    HREADYOUT_S;
  logic [NS-1:0]    HRESP_S;
  logic [NS*32-1:0] HRDATA_S;
  logic             err_valid, err_write, timeout, err_clr;
  logic [31:0]      err_addr;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ahbl_bus_gen #(
    .NUM_SLAVES (NS),
    .DEC_BITS   (8),
    .SLV_BASE   (48'h504C_4840_2048),
    .SLV_MASK   (48'hF0FF_FFFF_FFFF),
    .TIMEOUT_CYC(TO)
  ) dut (
    .HCLK       (clk),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .HSEL_S     (HSEL_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S    (HRESP_S),
    .HRDATA_S   (HRDATA_S),
    .err_valid  (err_valid),
    .err_addr   (err_addr),
    .err_write  (err_write),
    .timeout    (timeout),
    .err_clr    (err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_dp: -1 no data phase, 0..NS-1 real slave, NS unmapped (default slave)
  // m_err_left: remaining cycles of the two-cycle ERROR response
  int          m_dp = -1;
  int          m_err_left = 0;
  int          m_stall = 0;
  logic        m_ev = 1'b0, m_ew = 1'b0, m_to = 1'b0;
  logic [31:0] m_ea = 32'h0;

  function automatic int mdec(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((int'(a[31:24]) & M_MASK[i]) == (M_BASE[i] & M_MASK[i])) return i;
    return -1;
  endfunction

  function automatic logic m_ready();
    if (m_dp < 0) return 1'b1;
    if (m_dp < NS) return HREADYOUT_S[m_dp];
    return m_err_left != 2;
  endfunction

  function automatic logic m_resp();
    if (m_dp < 0) return 1'b0;
    if (m_dp < NS) return HRESP_S[m_dp];
    return m_err_left > 0;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (m_dp >= 0 && m_dp < NS) return HRDATA_S[m_dp*32 +: 32];
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    logic rdy, acc, set_to;
    int   idx;
    rdy    = m_ready();
    idx    = mdec(HADDR);
    acc    = rdy && HTRANS[1] && (idx < 0);
    set_to = 1'b0;
    if (HRESET) begin
      m_dp = -1; m_err_left = 0; m_stall = 0;
      m_ev = 1'b0; m_ew = 1'b0; m_to = 1'b0; m_ea = 32'h0;
    end else begin
      if (rdy) m_stall = 0;
      else if (m_dp >= 0 && m_dp < NS && m_stall < TO) begin
        m_stall++;
        if (m_stall == TO) set_to = 1'b1;
      end
      m_to = (m_to && !err_clr) || set_to;
      if (acc && (!m_ev || err_clr)) begin
        m_ev = 1'b1; m_ew = HWRITE; m_ea = HADDR;
      end else if (err_clr) begin
        m_ev = 1'b0; m_ew = 1'b0;
      end
      if (acc) m_err_left = 2;
      else if (m_err_left > 0) m_err_left--;
      if (rdy) m_dp = (idx < 0) ? NS : idx;
    end
  end

  always @(negedge clk) begin : compare
    logic [NS-1:0] e_sel;
    int idx;
    if (chk_en) begin
      idx   = mdec(HADDR);
      e_sel = '0;
      if (idx >= 0) e_sel[idx] = 1'b1;
      chk("m_HSEL_S", 32'(HSEL_S), 32'(e_sel));
      chk("m_HREADY", 32'(HREADY), 32'(m_ready()));
      chk("m_HRESP", 32'(HRESP), 32'(m_resp()));
      chk("m_HRDATA", HRDATA, m_rdata());
      chk("m_err_valid", 32'(err_valid), 32'(m_ev));
      chk("m_err_addr", err_addr, m_ea);
      chk("m_err_write", 32'(err_write), 32'(m_ew));
      chk("m_timeout", 32'(timeout), 32'(m_to));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clk);
  endtask

  initial begin
    HRESET = 1'b1; HADDR = 32'h4000_0000; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    err_clr = 1'b0; HREADYOUT_S = '1; HRESP_S = '0;
    for (int i = 0; i < NS; i++) HRDATA_S[i*32 +: 32] = 32'hA000_0000 | i;
    next(); next();
    at_mid();
    chk_en = 1'b1;
    chk("rst_hsel", 32'(HSEL_S), 32'h04);
    chk("rst_hready", 32'(HREADY), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_err_valid", 32'(err_valid), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    next();
    HRESET = 1'b0;

    // NONSEQ read to slave 2, zero-wait
    HADDR = 32'h4000_0010; HTRANS = HTRANS_NONSEQ; HRDATA_S[2*32 +: 32] = 32'hDEAD_BEEF;
    at_mid(); chk("rd_hsel", 32'(HSEL_S), 32'h04);
    next();
    HTRANS = HTRANS_IDLE; HADDR = 32'h0;
    at_mid();
    chk("rd_hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("rd_hresp", 32'(HRESP), 32'h0);
    chk("rd_hready", 32'(HREADY), 32'h1);
    next();

    // overlapping windows: slave 0 beats slave 3; masked window of slave 5
    HADDR = 32'h4800_0000; HTRANS = HTRANS_NONSEQ;
    at_mid(); chk("ovl_hsel", 32'(HSEL_S), 32'h01);
    next();
    HTRANS = HTRANS_IDLE; HADDR = 32'h5A00_0000;
    at_mid();
    chk("ovl_hrdata", HRDATA, 32'hA000_0000);
    chk("mask_hsel", 32'(HSEL_S), 32'h20);
    next();

    // unmapped write
    HADDR = 32'hF000_0000; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
    at_mid();
    chk("unm_hsel", 32'(HSEL_S), 32'h0);
    chk("unm_hready_addr", 32'(HREADY), 32'h1);
    next();
    HTRANS = HTRANS_IDLE; HADDR = 32'h2000_0000; HWRITE = 1'b0;
    at_mid();
    chk("err1_hready", 32'(HREADY), 32'h0);
    chk("err1_hresp", 32'(HRESP), 32'h1);
    chk("err1_valid", 32'(err_valid), 32'h1);
    chk("err1_addr", err_addr, 32'hF000_0000);
    chk("err1_write", 32'(err_write), 32'h1);
    next();
    at_mid();
    chk("err2_hready", 32'(HREADY), 32'h1);
    chk("err2_hresp", 32'(HRESP), 32'h1);
    next();

    // second error must not overwrite; back-to-back error from DS_ERR2
    HADDR = 32'hE000_0004; HTRANS = HTRANS_NONSEQ;
    next();
    HTRANS = HTRANS_IDLE;
    next();
    HADDR = 32'hC000_0000; HTRANS = HTRANS_NONSEQ;
    at_mid(); chk("b2b_err2_hresp", 32'(HRESP), 32'h1);
    next();
    HTRANS = HTRANS_IDLE;
    at_mid();
    chk("b2b_err1_hready", 32'(HREADY), 32'h0);
    chk("keep_addr", err_addr, 32'hF000_0000);
    chk("keep_write", 32'(err_write), 32'h1);
    next(); next();

    // err_clr coincident with a new unmapped access: new error captured
    HADDR = 32'hD000_0000; HTRANS = HTRANS_NONSEQ; err_clr = 1'b1;
    next();
    err_clr = 1'b0; HTRANS = HTRANS_IDLE;
    at_mid();
    chk("clrset_valid", 32'(err_valid), 32'h1);
    chk("clrset_addr", err_addr, 32'hD000_0000);
    chk("clrset_write", 32'(err_write), 32'h0);
    next(); next();

    // BUSY to an unmapped address: zero-wait OKAY
    HTRANS = HTRANS_BUSY; HADDR = 32'hF000_0000;
    next();
    HTRANS = HTRANS_IDLE;
    at_mid();
    chk("busy_hready", 32'(HREADY), 32'h1);
    chk("busy_hresp", 32'(HRESP), 32'h0);
    chk("busy_hrdata", HRDATA, 32'h0);
    next();

    err_clr = 1'b1;
    next();
    err_clr = 1'b0;
    at_mid();
    chk("clr_valid", 32'(err_valid), 32'h0);
    chk("clr_addr_hold", err_addr, 32'hD000_0000);
    next();

    // slave 1 stall for 6 cycles
    HADDR = 32'h2000_0000; HTRANS = HTRANS_NONSEQ;
    next();
    HTRANS = HTRANS_IDLE;
    for (int k = 1; k <= 6; k++) begin
      HREADYOUT_S[1] = 1'b0;
      at_mid();
      if (k == 1) chk("stall_hready", 32'(HREADY), 32'h0);
      if (k == 4) chk("to_before", 32'(timeout), 32'h0);
      if (k == 5) chk("to_after4", 32'(timeout), 32'h1);
      next();
    end
    HREADYOUT_S[1] = 1'b1;
    at_mid();
    chk("stall_end_hready", 32'(HREADY), 32'h1);
    chk("to_sticky", 32'(timeout), 32'h1);
    next();
    err_clr = 1'b1;
    next();
    err_clr = 1'b0;
    at_mid(); chk("to_cleared", 32'(timeout), 32'h0);
    next();

    // err_clr on the same edge the count reaches the limit: timeout wins
    for (int k = 1; k <= 5; k++) begin
      HREADYOUT_S[1] = 1'b0;
      err_clr = (k == 4);
      at_mid();
      if (k == 5) chk("to_clr_race", 32'(timeout), 32'h1);
      next();
    end
    err_clr = 1'b0; HREADYOUT_S[1] = 1'b1;
    next();
    err_clr = 1'b1;
    next();
    err_clr = 1'b0;

    // reset during DS_ERR1
    HADDR = 32'hF000_0000; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
    next();
    HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HRESET = 1'b1;
    at_mid(); chk("pre_rst_hready", 32'(HREADY), 32'h0);
    next();
    HRESET = 1'b0;
    at_mid();
    chk("post_rst_hready", 32'(HREADY), 32'h1);
    chk("post_rst_hresp", 32'(HRESP), 32'h0);
    chk("post_rst_valid", 32'(err_valid), 32'h0);
    next();

    HADDR = 32'h4C00_0000; HTRANS = HTRANS_NONSEQ;
    at_mid(); chk("s4_hsel", 32'(HSEL_S), 32'h10);
    next();
    HTRANS = HTRANS_IDLE;
    at_mid(); chk("s4_hrdata", HRDATA, 32'hA000_0004);
    next();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
